// File: rtl/fp_mul_elastic.sv
// Elastic FP significand multiplier with IEEE special-case detection.
// Optional synchronous pipeline flush: define FP_MUL_FLUSH_EN.
module fp_mul_elastic #(
  parameter int EXPO_W     = 11,
  parameter int FRAC_W     = 52,
  parameter int MUL_STAGES = 2,
  parameter int ID_W       = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef FP_MUL_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ID_W-1:0]       in_id,
  input  logic                  in_fma,
  input  logic                  in_rs1_sign,
  input  logic                  in_rs2_sign,
  input  logic [EXPO_W-1:0]     in_rs1_expo,
  input  logic [EXPO_W-1:0]     in_rs2_expo,
  input  logic [FRAC_W-1:0]     in_rs1_frac,
  input  logic [FRAC_W-1:0]     in_rs2_frac,
  input  logic                  in_rs1_hidden,
  input  logic                  in_rs2_hidden,
  input  logic [EXPO_W-1:0]     in_rs2_shift,
  input  logic [3:0]            in_rs1_special,
  input  logic [3:0]            in_rs2_special,
  output logic                  out_valid,
  input  logic                  out_ack,
  output logic                  add_valid,
  input  logic                  add_ready,
  output logic [ID_W-1:0]       res_id,
  output logic                  res_sign,
  output logic [EXPO_W+1:0]     res_expo,
  output logic [2*FRAC_W+1:0]   res_sig,
  output logic                  res_sticky,
  output logic                  res_nv,
  output logic                  res_inf,
  output logic                  res_qnan,
  output logic                  res_zero
);

  localparam int NS = MUL_STAGES;
  localparam int SW = FRAC_W + 1;
  localparam int LO = SW / 2;
  localparam int HI = SW - LO;
  localparam int PW = 2 * SW;
  localparam int EW = EXPO_W + 2;
  localparam logic [EW-1:0] BIAS = {{3{1'b0}}, {(EXPO_W-1){1'b1}}};

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            fma;
    logic            sign;
    logic [EW-1:0]   expo;
    logic            nv;
    logic            inf;
    logic            qnan;
    logic            zero;
    logic            sticky;
  } meta_t;

  logic          flush_w;
  logic [NS:0]   v_q, v_d, adv;
  logic          drain;
  meta_t         meta_d;
  meta_t         meta_q [NS+1];
  logic [SW-1:0] sig_a_d, sig_b_d, sig_a_q, sig_b_q;
  logic [PW-1:0] prod_d, prod_q;
  logic          h2n;

`ifdef FP_MUL_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign h2n = ~in_rs2_hidden;

  always_comb begin
    logic sn1, qn1, if1, z1, sn2, qn2, if2, z2, spec;
    {sn1, qn1, if1, z1} = in_rs1_special;
    {sn2, qn2, if2, z2} = in_rs2_special;
    meta_d      = '0;
    meta_d.id   = in_id;
    meta_d.fma  = in_fma;
    meta_d.sign = in_rs1_sign ^ in_rs2_sign;
    meta_d.nv   = (z1 & if2) | (if1 & z2) | sn1 | sn2;
    meta_d.qnan = meta_d.nv | sn1 | sn2 | qn1 | qn2;
    meta_d.inf  = ((if1 & ~z2) | (~z1 & if2)) & ~meta_d.qnan;
    meta_d.zero = (z1 | z2) & ~meta_d.qnan;
    meta_d.sticky = ~in_rs1_hidden & ~in_rs2_hidden & ~meta_d.zero;
    spec = meta_d.inf | meta_d.qnan | meta_d.zero | meta_d.sticky;
    // Specials zero the significands so the product lane emits zero.
    meta_d.expo = spec ? '0 :
      EW'(in_rs1_expo) + EW'(in_rs2_expo) + EW'(h2n)
      - EW'(in_rs2_shift) - BIAS;
    sig_a_d = spec ? '0 : {in_rs1_hidden, in_rs1_frac};
    sig_b_d = spec ? '0 : {in_rs2_hidden, in_rs2_frac};
  end

  assign out_valid = v_q[NS] & ~meta_q[NS].fma;
  assign add_valid = v_q[NS] & meta_q[NS].fma;
  assign drain = (out_valid & out_ack) | (add_valid & add_ready);

  // A stage may load when the output drains or any later stage is empty.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    adv = '0;
    for (int i = NS; i >= 0; i--) begin
      all_full = all_full & v_q[i];
      adv[i] = drain | ~all_full;
    end
  end

  always_comb begin
    v_d = v_q;
    if (adv[0]) v_d[0] = in_valid;
    for (int i = 1; i <= NS; i++)
      if (adv[i]) v_d[i] = v_q[i-1];
    if (flush_w) v_d = '0;
  end

  assign in_ready = adv[0] | flush_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  always_ff @(posedge clk) begin
    if (adv[0]) begin
      meta_q[0] <= meta_d;
      sig_a_q   <= sig_a_d;
      sig_b_q   <= sig_b_d;
    end
    for (int i = 1; i <= NS; i++)
      if (adv[i]) meta_q[i] <= meta_q[i-1];
    if (adv[NS]) prod_q <= prod_d;
  end

  generate
    if (NS == 1) begin : g_one
      assign prod_d = sig_a_q * sig_b_q;
    end else begin : g_pp
      logic [SW+LO-1:0] pl_d;
      logic [SW+HI-1:0] ph_d;
      logic [SW+LO-1:0] pl_q [NS-1];
      logic [SW+HI-1:0] ph_q [NS-1];
      assign pl_d = sig_a_q * sig_b_q[LO-1:0];
      assign ph_d = sig_a_q * sig_b_q[SW-1:LO];
      always_ff @(posedge clk) begin
        if (adv[1]) begin
          pl_q[0] <= pl_d;
          ph_q[0] <= ph_d;
        end
        for (int i = 1; i < NS-1; i++)
          if (adv[i+1]) begin
            pl_q[i] <= pl_q[i-1];
            ph_q[i] <= ph_q[i-1];
          end
      end
      assign prod_d = PW'(pl_q[NS-2])
                    + {ph_q[NS-2], {LO{1'b0}}};
    end
  endgenerate

  assign res_id     = meta_q[NS].id;
  assign res_sign   = meta_q[NS].sign;
  assign res_expo   = meta_q[NS].expo;
  assign res_sig    = prod_q;
  assign res_sticky = meta_q[NS].sticky;
  assign res_nv     = meta_q[NS].nv;
  assign res_inf    = meta_q[NS].inf;
  assign res_qnan   = meta_q[NS].qnan;
  assign res_zero   = meta_q[NS].zero;

endmodule

// File: tb/tb_fp_mul_elastic.sv
// Directed bench for fp_mul_elastic (default widths).
module tb_fp_mul_elastic;

`ifdef FP_MUL_FLUSH_EN
  localparam int NS = 4;
`else
  localparam int NS = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [2:0] in_id = '0;
  logic in_fma = 1'b0;
  logic in_rs1_sign = 1'b0, in_rs2_sign = 1'b0;
  logic [10:0] in_rs1_expo = '0, in_rs2_expo = '0, in_rs2_shift = '0;
  logic [51:0] in_rs1_frac = '0, in_rs2_frac = '0;
  logic in_rs1_hidden = 1'b0, in_rs2_hidden = 1'b0;
  logic [3:0] in_rs1_special = '0, in_rs2_special = '0;
  logic out_valid, add_valid;
  logic out_ack = 1'b1, add_ready = 1'b1;
  logic [2:0] res_id;
  logic res_sign, res_sticky, res_nv, res_inf, res_qnan, res_zero;
  logic [12:0] res_expo;
  logic [105:0] res_sig;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_mul_elastic #(.MUL_STAGES(NS)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef FP_MUL_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
    .in_fma(in_fma),
    .in_rs1_sign(in_rs1_sign), .in_rs2_sign(in_rs2_sign),
    .in_rs1_expo(in_rs1_expo), .in_rs2_expo(in_rs2_expo),
    .in_rs1_frac(in_rs1_frac), .in_rs2_frac(in_rs2_frac),
    .in_rs1_hidden(in_rs1_hidden), .in_rs2_hidden(in_rs2_hidden),
    .in_rs2_shift(in_rs2_shift),
    .in_rs1_special(in_rs1_special), .in_rs2_special(in_rs2_special),
    .out_valid(out_valid), .out_ack(out_ack),
    .add_valid(add_valid), .add_ready(add_ready),
    .res_id(res_id), .res_sign(res_sign), .res_expo(res_expo),
    .res_sig(res_sig), .res_sticky(res_sticky), .res_nv(res_nv),
    .res_inf(res_inf), .res_qnan(res_qnan), .res_zero(res_zero)
  );

  task automatic set_op(
    input logic [2:0] id, input logic fma,
    input logic s1, input logic [10:0] e1, input logic [51:0] f1,
    input logic h1, input logic [3:0] sp1,
    input logic s2, input logic [10:0] e2, input logic [51:0] f2,
    input logic h2, input logic [10:0] sh2, input logic [3:0] sp2);
    in_id = id; in_fma = fma;
    in_rs1_sign = s1; in_rs1_expo = e1; in_rs1_frac = f1;
    in_rs1_hidden = h1; in_rs1_special = sp1;
    in_rs2_sign = s2; in_rs2_expo = e2; in_rs2_frac = f2;
    in_rs2_hidden = h2; in_rs2_shift = sh2; in_rs2_special = sp2;
  endtask

  task automatic issue();
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!(out_valid || add_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (add_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_add_valid got=%b exp=0", add_valid);
    end
  endtask

  task automatic test_basic();
    int n;
    logic [105:0] exp_sig;
    exp_sig = 106'd3 << 103;
    set_op(3'd5, 1'b0, 1'b0, 11'd1023, 52'h8000000000000, 1'b1, 4'h0,
           1'b0, 11'd1024, 52'h0, 1'b1, 11'd0, 4'h0);
    issue();
    wait_out(n);
    checks++;
    if (n !== NS) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=%0d", n + 1, NS + 1);
    end
    checks++;
    if (out_valid !== 1'b1 || add_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_port got=%b%b exp=10", out_valid, add_valid);
    end
    checks++;
    if (res_expo !== 13'd1024) begin
      failures++;
      $display("FAIL basic_expo got=%h exp=400", res_expo);
    end
    checks++;
    if (res_sig !== exp_sig) begin
      failures++;
      $display("FAIL basic_sig got=%h exp=%h", res_sig, exp_sig);
    end
    checks++;
    if ({res_nv, res_inf, res_qnan, res_zero, res_sticky, res_sign} !== 6'b0) begin
      failures++;
      $display("FAIL basic_flags got=%b%b%b%b%b%b exp=000000",
               res_nv, res_inf, res_qnan, res_zero, res_sticky, res_sign);
    end
    checks++;
    if (res_id !== 3'd5) begin
      failures++;
      $display("FAIL basic_id got=%0d exp=5", res_id);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_consumed got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_invalid();
    int n;
    set_op(3'd2, 1'b1, 1'b0, 11'd0, 52'h0, 1'b0, 4'b0001,
           1'b0, 11'd2047, 52'h0, 1'b1, 11'd0, 4'b0010);
    issue();
    wait_out(n);
    checks++;
    if (add_valid !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL nv_port got=%b%b exp=01", out_valid, add_valid);
    end
    checks++;
    if ({res_nv, res_qnan, res_inf, res_zero, res_sticky} !== 5'b11000) begin
      failures++;
      $display("FAIL nv_flags got=%b%b%b%b%b exp=11000",
               res_nv, res_qnan, res_inf, res_zero, res_sticky);
    end
    checks++;
    if (res_sig !== 106'd0 || res_expo !== 13'd0) begin
      failures++;
      $display("FAIL nv_zeroed got=%h/%h exp=0/0", res_sig, res_expo);
    end
  endtask

  task automatic test_infinity();
    int n;
    set_op(3'd3, 1'b0, 1'b1, 11'd2047, 52'h0, 1'b1, 4'b0010,
           1'b0, 11'd1024, 52'h0, 1'b1, 11'd0, 4'b0000);
    issue();
    wait_out(n);
    checks++;
    if ({res_inf, res_nv, res_qnan, res_zero, res_sign} !== 5'b10001) begin
      failures++;
      $display("FAIL inf_flags got=%b%b%b%b%b exp=10001",
               res_inf, res_nv, res_qnan, res_zero, res_sign);
    end
    checks++;
    if (res_sig !== 106'd0 || res_expo !== 13'd0) begin
      failures++;
      $display("FAIL inf_zeroed got=%h/%h exp=0/0", res_sig, res_expo);
    end
  endtask

  task automatic test_underflow();
    int n;
    logic [105:0] exp_sig;
    exp_sig = 106'd3 << 103;
    set_op(3'd4, 1'b0, 1'b1, 11'd1, 52'h0, 1'b1, 4'h0,
           1'b0, 11'd1, 52'h8000000000000, 1'b1, 11'd0, 4'h0);
    issue();
    wait_out(n);
    checks++;
    if (res_expo !== 13'h1C03) begin
      failures++;
      $display("FAIL uflow_expo got=%h exp=1c03", res_expo);
    end
    checks++;
    if (res_sig !== exp_sig) begin
      failures++;
      $display("FAIL uflow_sig got=%h exp=%h", res_sig, exp_sig);
    end
    checks++;
    if (res_sign !== 1'b1) begin
      failures++;
      $display("FAIL uflow_sign got=%b exp=1", res_sign);
    end
  endtask

  task automatic test_full_product();
    int n;
    logic [105:0] exp_sig;
    exp_sig = ({106{1'b1}} << 54) | 106'd1;
    set_op(3'd6, 1'b0, 1'b0, 11'd1023, {52{1'b1}}, 1'b1, 4'h0,
           1'b0, 11'd1023, {52{1'b1}}, 1'b1, 11'd0, 4'h0);
    issue();
    wait_out(n);
    checks++;
    if (res_sig !== exp_sig) begin
      failures++;
      $display("FAIL ones_sig got=%h exp=%h", res_sig, exp_sig);
    end
    checks++;
    if (res_expo !== 13'd1023) begin
      failures++;
      $display("FAIL ones_expo got=%h exp=3ff", res_expo);
    end
  endtask

  task automatic test_shift();
    int n;
    logic [105:0] exp_sig;
    exp_sig = 106'd1 << 103;
    set_op(3'd1, 1'b0, 1'b0, 11'd1023, 52'h0, 1'b1, 4'h0,
           1'b0, 11'd0, 52'h8000000000000, 1'b0, 11'd3, 4'h0);
    issue();
    wait_out(n);
    checks++;
    if (res_expo !== 13'h1FFE) begin
      failures++;
      $display("FAIL shift_expo got=%h exp=1ffe", res_expo);
    end
    checks++;
    if (res_sig !== exp_sig || res_sticky !== 1'b0) begin
      failures++;
      $display("FAIL shift_sig got=%h/%b exp=%h/0", res_sig, res_sticky, exp_sig);
    end
  endtask

  task automatic test_subnormal();
    int n;
    set_op(3'd7, 1'b0, 1'b0, 11'd0, 52'h1234, 1'b0, 4'h0,
           1'b0, 11'd0, 52'h8000000000000, 1'b0, 11'd0, 4'h0);
    issue();
    wait_out(n);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL sub_valid got=%b exp=1", out_valid);
    end
    checks++;
    if ({res_sticky, res_zero, res_nv, res_inf, res_qnan} !== 5'b10000) begin
      failures++;
      $display("FAIL sub_flags got=%b%b%b%b%b exp=10000",
               res_sticky, res_zero, res_nv, res_inf, res_qnan);
    end
    checks++;
    if (res_sig !== 106'd0 || res_expo !== 13'd0) begin
      failures++;
      $display("FAIL sub_zeroed got=%h/%h exp=0/0", res_sig, res_expo);
    end
  endtask

  task automatic test_mid_reset();
    int bad;
    bad = 0;
    set_op(3'd2, 1'b0, 1'b0, 11'd1023, 52'h0, 1'b1, 4'h0,
           1'b0, 11'd1023, 52'h0, 1'b1, 11'd0, 4'h0);
    issue();
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || add_valid) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL midrst_outputs got=%0d exp=0", bad);
    end
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int exp_id;
    logic saw_stall;
    int drv_to;
    exp_id = 0;
    saw_stall = 1'b0;
    drv_to = 0;
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          logic rdy;
          int tries;
          tries = 0;
          set_op(3'(k), 1'b0, 1'b0, 11'(1000 + k), 52'h0, 1'b1, 4'h0,
                 1'b0, 11'd1023, 52'h0, 1'b1, 11'd0, 4'h0);
          in_valid = 1'b1;
          do begin
            #1 rdy = in_ready;
            @(negedge clk);
            tries++;
          end while (!rdy && tries < 50);
          if (!rdy) drv_to++;
        end
        in_valid = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 60; cyc++) begin
          out_ack = (cyc >= 8);
          #2;
          if (!in_ready) saw_stall = 1'b1;
          if (out_valid) begin
            checks++;
            if (res_id !== 3'(exp_id) || res_expo !== 13'(1000 + exp_id)) begin
              failures++;
              $display("FAIL b2b_order got=%0d/%0d exp=%0d/%0d",
                       res_id, res_expo, exp_id, 1000 + exp_id);
            end
            if (out_ack) exp_id++;
          end
          @(negedge clk);
        end
      end
    join
    out_ack = 1'b1;
    checks++;
    if (exp_id !== 8 || drv_to !== 0) begin
      failures++;
      $display("FAIL b2b_count got=%0d timeouts=%0d exp=8/0", exp_id, drv_to);
    end
    checks++;
    if (saw_stall !== 1'b1) begin
      failures++;
      $display("FAIL b2b_stall got=%b exp=1", saw_stall);
    end
  endtask

`ifdef FP_MUL_FLUSH_EN
  task automatic test_flush();
    int n, bad;
    bad = 0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      set_op(3'(k), 1'b0, 1'b0, 11'd1023, 52'h0, 1'b1, 4'h0,
             1'b0, 11'd1023, 52'h0, 1'b1, 11'd0, 4'h0);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_id = 3'd7;
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_ready got=%b exp=1", in_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (8) begin
      if (out_valid || add_valid) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL flush_outputs got=%0d exp=0", bad);
    end
    in_id = 3'd5;
    issue();
    wait_out(n);
    checks++;
    if (n !== 4 || out_valid !== 1'b1 || res_id !== 3'd5) begin
      failures++;
      $display("FAIL flush_next got=lat%0d/v%b/id%0d exp=lat5/v1/id5",
               n + 1, out_valid, res_id);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_infinity();
    test_underflow();
    test_full_product();
    test_shift();
    test_subnormal();
    test_mid_reset();
    test_basic();
    test_back_to_back();
`ifdef FP_MUL_FLUSH_EN
    test_flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
